csi_rx_vc_packet_handler: RTL
=============================

# csi_rx_vc_packet_handler

Multi-virtual-channel CSI-2 packet handler. Sits after `dphy_rx_word_combiner` in the receiver chain and consumes 32-bit combined words. It parses the packet header (DI, WC, ECC) and uses the word count to end each long packet exactly. It tracks frame and line state independently for up to four virtual channels, and flags header-ECC and length errors; video payload is forwarded tagged with its VC.

## Interface
Parameters:
- `NUM_VC`, 4: number of tracked virtual channels, 1..4; VC field values >= NUM_VC are dropped.
- `VC_EN`, 4'b1111: per-VC enable mask; packets on disabled VCs are consumed silently.
- `FS_DT`, 6'h00: frame start data type.
- `FE_DT`, 6'h01: frame end data type.
- `VIDEO_DT`, 6'h2A: video payload data type.
- `MAX_LEN`, 16'd8192: maximum words per long packet, CRC words included.
- `CHECK_ECC`, 1'b1: when 1, a header-ECC mismatch discards the packet.

Ports:
- `clock` in 1: word clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: when low, all state holds and no output pulses are generated.
- `data` in 32: combined word; byte 0 is in [7:0].
- `data_enable` in 1: `data` valid this cycle.
- `data_frame` in 1: combiner is inside a packet.
- `lp_detect` in 1: LP state detected on the lane.
- `sync_wait` out 1: high while waiting for the next sync/header.
- `packet_done` out 1: one-cycle pulse that releases the aligner and combiner.
- `payload` out 32: video payload word.
- `payload_enable` out 1: `payload` valid.
- `payload_frame` out 1: high for the whole forwarded payload of a line.
- `payload_vc` out 2: VC of the current payload.
- `vsync` out NUM_VC: one-cycle pulse per VC on frame start.
- `in_frame` out NUM_VC: per-VC frame state.
- `in_line` out NUM_VC: per-VC line state.
- `ecc_err` out 1: one-cycle pulse on an ECC mismatch.
- `len_err` out 1: one-cycle pulse on a MAX_LEN overrun or LP abort.

## Operation
- The FSM has four states: WAIT_HDR, LONG, DRAIN and DONE.
- **WAIT_HDR** (`sync_wait`=1):
  - The first word with `data_enable` && `data_frame` is taken as the header: DI=[7:0], WC=[23:8], ECC=[31:24].
  - ECC uses the CSI-2 6-bit Hamming code over 24 bits; ECC bits [7:6] must be 0.
  - On a mismatch with CHECK_ECC=1: pulse `ecc_err`, then go to DONE.
- **Short packets** (DT < 6'h10) go to DONE.
  - FS on an enabled VC sets `in_frame[vc]` and pulses `vsync[vc]`.
  - FE clears `in_frame[vc]`.
  - FE while not in frame is ignored. FS while already in frame keeps the flag set and pulses `vsync` again.
- **Long packets** go to LONG with:
  - `total` = ceil((WC+2)/4), saturated at MAX_LEN, with the overrun remembered;
  - `pay` = ceil(WC/4).
- **LONG**:
  - Each `data_enable` word increments the 16-bit counter `cnt`.
  - A word is forwarded when all of the following hold: DT==VIDEO_DT, the VC is enabled, `in_frame[vc]` is set, and `cnt` < `pay`. Forwarding asserts `payload_enable` and raises `in_line[vc]` and `payload_frame` for the line.
  - The remaining (CRC) words are consumed and not forwarded.
  - When `cnt` reaches `total`, go to DONE; pulse `len_err` if the length was saturated.
- **DONE**:
  - Pulse `packet_done` for one cycle.
  - Clear `in_line` and `payload_frame`.
  - Return to WAIT_HDR.
- **Abort:** `lp_detect` high in LONG moves to DONE next cycle and pulses `len_err`. In WAIT_HDR it is ignored.
- **VC range:** VC >= NUM_VC is treated as a disabled VC.

## Timing
- Reset values: `sync_wait`=1; all other outputs 0; state WAIT_HDR; `cnt`=0.
- Payload latency is one cycle: `payload`, `payload_enable` and `payload_vc` are registered from the `data` of the previous cycle.
- `vsync` and `in_frame` update the cycle after the header word is accepted.
- `packet_done` is asserted exactly one cycle after the last counted word, or after the header for short packets.
- `sync_wait` falls the cycle after the header is accepted and rises together with the `packet_done` cycle.
- `data_enable` low in LONG: `cnt` holds and no output is produced.
- `enable` low: everything freezes, including pulses, which are deferred.
- `reset` mid-packet: state returns to WAIT_HDR next cycle and all `in_frame` bits clear.
- `cnt` never wraps; it saturates at MAX_LEN.

## Structure
- Package `csi_rx_pkg` holds:
  - DT constants (FS/FE/LS/LE, RAW8/10/12);
  - header field offsets;
  - the FSM state enum;
  - the ECC parity masks.
- One sub-module, `csi_rx_header_ecc`: a combinational 24-to-6 ECC generator plus a compare output, instantiated once.
- The top block holds the FSM, the counter, the per-VC frame registers and the output registers.

## Test plan
- **FS, line, FE on VC0.**
  - Stimulus: FS on VC0 (header 32'hxx_0000_00 with correct ECC), then a RAW8 line with WC=16, then FE.
  - Required: `vsync[0]` pulses; `in_frame[0]`=1; exactly 4 `payload_enable`; 1 CRC word dropped; `packet_done` pulses after word 5; FE clears `in_frame[0]`.
- **Two interleaved VCs.**
  - Stimulus: FS on VC1 and VC2, then lines on both.
  - Required: `payload_vc` matches each line; `in_frame`=3'b110 (NUM_VC=3); a VC3 packet produces no output.
- **Bad ECC.**
  - Stimulus: header with ECC bit 0 flipped.
  - Required: `ecc_err` pulses; no `payload_enable`; `packet_done` pulses one cycle later; the next good packet is parsed normally.
- **Length overrun.**
  - Stimulus: WC=16'hFFFF with MAX_LEN=64.
  - Required: packet ends after 64 words with `len_err`=1 and `packet_done`=1.
- **LP abort.**
  - Stimulus: `lp_detect` asserted after the 3rd payload word.
  - Required: `len_err` and `packet_done` pulse next cycle; `in_line` clears; `sync_wait`=1.
- **Stalls and reset.**
  - Stimulus: `data_enable` gaps mid-line, then `reset` mid-line.
  - Required: word count is unaffected by the gaps; after reset, all outputs are at reset values and `sync_wait`=1.

Source files
------------

// File: rtl/csi_rx_pkg.sv
// Shared CSI-2 receive definitions: data types, header layout,
// packet-handler FSM states and header-ECC parity masks.
package csi_rx_pkg;

    localparam logic [5:0] DT_FS       = 6'h00;
    localparam logic [5:0] DT_FE       = 6'h01;
    localparam logic [5:0] DT_LS       = 6'h02;
    localparam logic [5:0] DT_LE       = 6'h03;
    localparam logic [5:0] DT_RAW8     = 6'h2A;
    localparam logic [5:0] DT_RAW10    = 6'h2B;
    localparam logic [5:0] DT_RAW12    = 6'h2C;
    localparam logic [5:0] DT_LONG_MIN = 6'h10;

    localparam int DI_LSB  = 0;
    localparam int WC_LSB  = 8;
    localparam int ECC_LSB = 24;

    typedef enum logic [1:0] {
        WAIT_HDR,
        LONG,
        DRAIN,
        DONE
    } state_t;

    // Parity bit i is the XOR of the header bits selected by ECC_MASK[i]
    localparam logic [5:0][23:0] ECC_MASK = {
        24'hEFFC00,
        24'hDF03F0,
        24'hB8E38E,
        24'h749A6D,
        24'hF2555B,
        24'hF12CB7
    };

    // ceil((n + add) / 4) without losing the carry out of 16 bits
    function automatic logic [15:0] div4_ceil(
        input logic [15:0] n,
        input logic [2:0]  add
    );
        logic [16:0] s;
        s = {1'b0, n} + {14'd0, add};
        return 16'(s >> 2);
    endfunction

endpackage

// File: rtl/csi_rx_header_ecc.sv
// Combinational CSI-2 header ECC: 6-bit Hamming code over DI+WC and
// a compare against the received ECC byte (top two bits must be 0).
// Ports: hdr (24-bit DI/WC), ecc_in (received byte), match (ECC ok).
module csi_rx_header_ecc
    import csi_rx_pkg::*;
(
    input  logic [23:0] hdr,
    input  logic [7:0]  ecc_in,
    output logic        match
);

    logic [5:0] ecc;

    always_comb begin
        ecc = '0;
        for (int i = 0; i < 6; i++) begin
            ecc[i] = ^(hdr & ECC_MASK[i]);
        end
    end

    assign match = (ecc_in == {2'b00, ecc});

endmodule

// File: rtl/csi_rx_vc_packet_handler.sv
// CSI-2 packet handler: parses headers, counts long packets by WC,
// tracks frame/line state per VC and forwards video payload.
// Ports: clock/reset/enable, combined word input (data, data_enable,
// data_frame, lp_detect), sync_wait/packet_done back to the aligner,
// payload stream with VC tag, per-VC vsync/in_frame/in_line, errors.
module csi_rx_vc_packet_handler
    import csi_rx_pkg::*;
#(
    parameter int          NUM_VC    = 4,
    parameter logic [3:0]  VC_EN     = 4'b1111,
    parameter logic [5:0]  FS_DT     = DT_FS,
    parameter logic [5:0]  FE_DT     = DT_FE,
    parameter logic [5:0]  VIDEO_DT  = DT_RAW8,
    parameter logic [15:0] MAX_LEN   = 16'd8192,
    parameter logic        CHECK_ECC = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [31:0]       data,
    input  logic              data_enable,
    input  logic              data_frame,
    input  logic              lp_detect,
    output logic              sync_wait,
    output logic              packet_done,
    output logic [31:0]       payload,
    output logic              payload_enable,
    output logic              payload_frame,
    output logic [1:0]        payload_vc,
    output logic [NUM_VC-1:0] vsync,
    output logic [NUM_VC-1:0] in_frame,
    output logic [NUM_VC-1:0] in_line,
    output logic              ecc_err,
    output logic              len_err
);

    state_t            state;
    logic [15:0]       cnt;
    logic [15:0]       total;
    logic [15:0]       pay;
    logic              ovf;
    logic              fwd;
    logic [1:0]        pkt_vc;
    logic              pd_q;
    logic              pe_q;
    logic              ecce_q;
    logic              lene_q;
    logic [NUM_VC-1:0] vs_q;

    logic              hdr_valid;
    logic              ecc_match;
    logic [1:0]        vc;
    logic [5:0]        dt;
    logic [15:0]       wc;
    logic [15:0]       tot_raw;
    logic [15:0]       pay_raw;
    logic [15:0]       cnt_inc;
    logic [NUM_VC-1:0] vc_oh;
    logic [NUM_VC-1:0] pkt_oh;
    logic              vc_ok;

    // Out-of-range VCs map to an empty mask and are treated as disabled
    function automatic logic [NUM_VC-1:0] onehot(input logic [1:0] v);
        logic [NUM_VC-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            if (v == 2'(i)) m[i] = 1'b1;
        end
        return m;
    endfunction

    csi_rx_header_ecc u_ecc (
        .hdr    (data[ECC_LSB-1:0]),
        .ecc_in (data[ECC_LSB +: 8]),
        .match  (ecc_match)
    );

    assign hdr_valid = data_enable && data_frame;
    assign dt        = data[DI_LSB +: 6];
    assign vc        = data[DI_LSB+6 +: 2];
    assign wc        = data[WC_LSB +: 16];
    assign tot_raw   = div4_ceil(wc, 3'd5);
    assign pay_raw   = div4_ceil(wc, 3'd3);
    assign cnt_inc   = (cnt == MAX_LEN) ? cnt : cnt + 16'd1;
    assign vc_oh     = onehot(vc);
    assign pkt_oh    = onehot(pkt_vc);
    assign vc_ok     = (vc_oh != '0) && VC_EN[vc];

    // Pulses are held while frozen and appear once enable returns
    assign packet_done    = pd_q & enable;
    assign payload_enable = pe_q & enable;
    assign ecc_err        = ecce_q & enable;
    assign len_err        = lene_q & enable;
    assign vsync          = vs_q & {NUM_VC{enable}};

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= WAIT_HDR;
            cnt           <= '0;
            total         <= '0;
            pay           <= '0;
            ovf           <= 1'b0;
            fwd           <= 1'b0;
            pkt_vc        <= '0;
            sync_wait     <= 1'b1;
            pd_q          <= 1'b0;
            pe_q          <= 1'b0;
            ecce_q        <= 1'b0;
            lene_q        <= 1'b0;
            vs_q          <= '0;
            payload       <= '0;
            payload_frame <= 1'b0;
            payload_vc    <= '0;
            in_frame      <= '0;
            in_line       <= '0;
        end else if (enable) begin
            pd_q   <= 1'b0;
            pe_q   <= 1'b0;
            ecce_q <= 1'b0;
            lene_q <= 1'b0;
            vs_q   <= '0;
            unique case (state)
                WAIT_HDR: begin
                    if (hdr_valid) begin
                        pkt_vc <= vc;
                        if (CHECK_ECC && !ecc_match) begin
                            ecce_q <= 1'b1;
                            pd_q   <= 1'b1;
                            state  <= DONE;
                        end else if (dt < DT_LONG_MIN) begin
                            pd_q  <= 1'b1;
                            state <= DONE;
                            if (vc_ok && dt == FS_DT) begin
                                in_frame <= in_frame | vc_oh;
                                vs_q     <= vc_oh;
                            end else if (vc_ok && dt == FE_DT) begin
                                in_frame <= in_frame & ~vc_oh;
                            end
                        end else begin
                            cnt       <= '0;
                            pay       <= pay_raw;
                            ovf       <= tot_raw > MAX_LEN;
                            total     <= (tot_raw > MAX_LEN) ? MAX_LEN : tot_raw;
                            fwd       <= vc_ok && dt == VIDEO_DT
                                         && (in_frame & vc_oh) != '0;
                            sync_wait <= 1'b0;
                            state     <= (pay_raw == '0) ? DRAIN : LONG;
                        end
                    end
                end
                LONG, DRAIN: begin
                    if (lp_detect) begin
                        lene_q    <= 1'b1;
                        pd_q      <= 1'b1;
                        sync_wait <= 1'b1;
                        state     <= DONE;
                    end else if (data_enable) begin
                        cnt <= cnt_inc;
                        if (fwd && cnt < pay) begin
                            payload       <= data;
                            pe_q          <= 1'b1;
                            payload_vc    <= pkt_vc;
                            payload_frame <= 1'b1;
                            in_line       <= in_line | pkt_oh;
                        end
                        if (cnt_inc >= total) begin
                            pd_q      <= 1'b1;
                            lene_q    <= ovf;
                            sync_wait <= 1'b1;
                            state     <= DONE;
                        end else if (cnt_inc >= pay) begin
                            state <= DRAIN;
                        end
                    end
                end
                DONE: begin
                    in_line       <= '0;
                    payload_frame <= 1'b0;
                    cnt           <= '0;
                    state         <= WAIT_HDR;
                end
                default: state <= WAIT_HDR;
            endcase
        end
    end

endmodule
